// File: rtl/lif_sweep_scheduler_pkg.sv
// Shared types, default dimensions and the saturating membrane update used by the
// LIF sweep scheduler and its update core.
package lif_pkg;

    localparam int LIF_NUM_NEURONS  = 8;
    localparam int LIF_V_WIDTH      = 8;
    localparam int LIF_LEAK_SHIFT   = 3;
    localparam int LIF_WEIGHT       = 64;
    localparam int LIF_THRESH_RST   = 200;
    localparam int LIF_REFRAC_TICKS = 2;
    localparam int ID_W             = $clog2(LIF_NUM_NEURONS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_EMIT = 2'd2
    } lif_state_e;

    // One extra bit of headroom catches the carry so the result can clamp at all-ones.
    function automatic logic [LIF_V_WIDTH-1:0] lif_update(
        input logic [LIF_V_WIDTH-1:0] v,
        input logic                   spk,
        input int unsigned            shift,
        input int unsigned            weight
    );
        logic [LIF_V_WIDTH:0] vx;
        logic [LIF_V_WIDTH:0] w;
        logic [LIF_V_WIDTH:0] sum;
        vx  = {1'b0, v};
        w   = spk ? weight[LIF_V_WIDTH:0] : '0;
        sum = vx - (vx >> shift) + w;
        return sum[LIF_V_WIDTH] ? {LIF_V_WIDTH{1'b1}} : sum[LIF_V_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/lif_sweep_scheduler_if.sv
// Output spike-event channel: valid/ready handshake carrying the firing neuron index.
interface lif_sweep_scheduler_if #(
    parameter int OUT_ID_W = lif_pkg::ID_W
);

    logic                out_valid;
    logic [OUT_ID_W-1:0] out_id;
    logic                out_ready;

    modport master (
        output out_valid,
        output out_id,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_id,
        output out_ready
    );

endinterface

// File: rtl/lif_sweep_scheduler_update_core.sv
// Combinational single-neuron LIF step: refractory countdown, leak + weighted input,
// threshold compare. Shared by every virtual neuron of the sweep.
module lif_update_core
    import lif_pkg::*;
#(
    parameter int V_WIDTH      = LIF_V_WIDTH,
    parameter int R_W          = $clog2(LIF_REFRAC_TICKS + 1),
    parameter int LEAK_SHIFT   = LIF_LEAK_SHIFT,
    parameter int WEIGHT       = LIF_WEIGHT,
    parameter int REFRAC_TICKS = LIF_REFRAC_TICKS
) (
    input  logic [V_WIDTH-1:0] v_i,
    input  logic               spk_i,
    input  logic [R_W-1:0]     refrac_i,
    input  logic [V_WIDTH-1:0] thr_i,
    output logic [V_WIDTH-1:0] next_v_o,
    output logic [R_W-1:0]     next_refrac_o,
    output logic               fire_o
);

    logic [V_WIDTH-1:0] sum;

    assign sum = lif_update(v_i, spk_i, LEAK_SHIFT, WEIGHT);

    // A refractory neuron is pinned at zero and deaf to its input bit.
    always_comb begin
        next_v_o      = v_i;
        next_refrac_o = refrac_i;
        fire_o        = 1'b0;
        if (refrac_i != '0) begin
            next_refrac_o = R_W'(refrac_i - 1'b1);
            next_v_o      = '0;
        end else if (sum >= thr_i) begin
            fire_o        = 1'b1;
            next_v_o      = '0;
            next_refrac_o = R_W'(REFRAC_TICKS);
        end else begin
            next_v_o      = sum;
        end
    end

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexed LIF array: each accepted tick sweeps all virtual neurons in index
// order through one shared update core and emits an event for every neuron that fires.
module lif_sweep_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS  = LIF_NUM_NEURONS,
    parameter int V_WIDTH      = LIF_V_WIDTH,
    parameter int LEAK_SHIFT   = LIF_LEAK_SHIFT,
    parameter int WEIGHT       = LIF_WEIGHT,
    parameter int THRESH_RST   = LIF_THRESH_RST,
    parameter int REFRAC_TICKS = LIF_REFRAC_TICKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_i,
    input  logic [NUM_NEURONS-1:0] spike_in_i,
    input  logic                   cfg_thresh_we_i,
    input  logic [V_WIDTH-1:0]     cfg_thresh_i,
    lif_sweep_scheduler_if.master  out_if,
    output logic                   busy_o,
    output logic                   sweep_done_o,
    output logic                   tick_overrun_o
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam int R_W   = $clog2(REFRAC_TICKS + 1);

    lif_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   done_q, done_d;
    logic                   ovr_q, ovr_d;
    logic [NUM_NEURONS-1:0] spk_q;
    logic [V_WIDTH-1:0]     thr_q;
    logic [V_WIDTH-1:0]     thresh_q;
    logic [V_WIDTH-1:0]     v_q      [NUM_NEURONS];
    logic [R_W-1:0]         refrac_q [NUM_NEURONS];

    logic                   accept_tick;
    logic                   write_en;
    logic                   last_idx;
    logic [V_WIDTH-1:0]     core_v;
    logic [R_W-1:0]         core_refrac;
    logic                   core_fire;

    assign last_idx = (idx_q == IDX_W'(NUM_NEURONS - 1));

    lif_update_core #(
        .V_WIDTH      (V_WIDTH),
        .R_W          (R_W),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .WEIGHT       (WEIGHT),
        .REFRAC_TICKS (REFRAC_TICKS)
    ) u_core (
        .v_i           (v_q[idx_q]),
        .spk_i         (spk_q[idx_q]),
        .refrac_i      (refrac_q[idx_q]),
        .thr_i         (thr_q),
        .next_v_o      (core_v),
        .next_refrac_o (core_refrac),
        .fire_o        (core_fire)
    );

    // Ticks are refused while sweeping and in the done cycle, so back-to-back sweeps
    // always present a clean sweep_done pulse.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        ovr_d       = ovr_q;
        accept_tick = 1'b0;
        write_en    = 1'b0;

        if (tick_i && ((state_q != ST_IDLE) || done_q)) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tick_i && !done_q) begin
                    accept_tick = 1'b1;
                    idx_d       = '0;
                    state_d     = ST_CALC;
                end
            end
            ST_CALC: begin
                write_en = 1'b1;
                if (core_fire) begin
                    state_d = ST_EMIT;
                end else if (last_idx) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = IDX_W'(idx_q + 1'b1);
                end
            end
            ST_EMIT: begin
                if (out_if.out_ready) begin
                    if (last_idx) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = IDX_W'(idx_q + 1'b1);
                        state_d = ST_CALC;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // thr_q samples the threshold before any same-cycle write lands in thresh_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            spk_q    <= '0;
            thr_q    <= V_WIDTH'(THRESH_RST);
            thresh_q <= V_WIDTH'(THRESH_RST);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            if (accept_tick) begin
                spk_q <= spike_in_i;
                thr_q <= thresh_q;
            end
            if (cfg_thresh_we_i) begin
                thresh_q <= cfg_thresh_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]      <= '0;
                refrac_q[i] <= '0;
            end
        end else if (write_en) begin
            v_q[idx_q]      <= core_v;
            refrac_q[idx_q] <= core_refrac;
        end
    end

    assign out_if.out_valid = (state_q == ST_EMIT);
    assign out_if.out_id    = idx_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign sweep_done_o     = done_q;
    assign tick_overrun_o   = ovr_q;

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Self-checking bench for lif_sweep_scheduler: directed scenarios plus a random run,
// all compared cycle by cycle against a sweep-level behavioural model.
module tb_lif_sweep_scheduler;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] spikeIn = '0;
    logic       cfgWe = 1'b0;
    logic [7:0] cfgThresh = '0;
    logic       busy;
    logic       sweepDone;
    logic       tickOverrun;

    lif_sweep_scheduler_if #(.OUT_ID_W(3)) outIf();

    lif_sweep_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick_i          (tick),
        .spike_in_i      (spikeIn),
        .cfg_thresh_we_i (cfgWe),
        .cfg_thresh_i    (cfgThresh),
        .out_if          (outIf),
        .busy_o          (busy),
        .sweep_done_o    (sweepDone),
        .tick_overrun_o  (tickOverrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Sweep-level model: a tick updates every neuron at once and lays out the sweep as
    // a queue of cycle slots (-1 = neuron update cycle, k >= 0 = event for neuron k).
    int q[$];
    int mv[N];
    int mr[N];
    int mCfg;
    bit mDone;
    bit mOvr;

    bit obsDone;
    bit obsValid;
    int obsId;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic void modelReset();
        q.delete();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mr[i] = 0;
        end
        mCfg  = 200;
        mDone = 1'b0;
        mOvr  = 1'b0;
    endfunction

    function automatic void startSweep(input logic [7:0] spk);
        int s;
        for (int i = 0; i < N; i++) begin
            q.push_back(-1);
            if (mr[i] != 0) begin
                mr[i]--;
                mv[i] = 0;
            end else begin
                s = mv[i] - mv[i] / 8 + (spk[i] ? 64 : 0);
                if (s > 255) s = 255;
                if (s >= mCfg) begin
                    q.push_back(i);
                    mv[i] = 0;
                    mr[i] = 2;
                end else begin
                    mv[i] = s;
                end
            end
        end
    endfunction

    function automatic void modelEdge();
        bit wasBusy;
        bit wasDone;
        bit newDone;
        wasBusy = (q.size() != 0);
        wasDone = mDone;
        newDone = 1'b0;
        if (wasBusy && (q[0] < 0 || outIf.out_ready)) begin
            void'(q.pop_front());
            if (q.size() == 0) newDone = 1'b1;
        end
        if (tick) begin
            if (wasBusy || wasDone) mOvr = 1'b1;
            else startSweep(spikeIn);
        end
        if (cfgWe) mCfg = int'(cfgThresh);
        mDone = newDone;
    endfunction

    task automatic checkCycle();
        bit eBusy;
        bit eValid;
        eBusy  = (q.size() != 0);
        eValid = eBusy && (q[0] >= 0);
        checkOutput("busy", int'(busy), int'(eBusy));
        checkOutput("out_valid", int'(outIf.out_valid), int'(eValid));
        if (eValid) checkOutput("out_id", int'(outIf.out_id), q[0]);
        checkOutput("sweep_done", int'(sweepDone), int'(mDone));
        checkOutput("tick_overrun", int'(tickOverrun), int'(mOvr));
        if (mDone) begin
            for (int i = 0; i < N; i++) begin
                checkOutput($sformatf("v[%0d]", i), int'(dut.v_q[i]), mv[i]);
                checkOutput($sformatf("refrac[%0d]", i), int'(dut.refrac_q[i]), mr[i]);
            end
        end
        obsDone  = sweepDone;
        obsValid = outIf.out_valid;
        obsId    = int'(outIf.out_id);
    endtask

    task automatic step();
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        if (!rst_n) modelReset();
        else modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input bit t, input logic [7:0] spk, input bit rdy);
        tick = t;
        spikeIn = spk;
        outIf.out_ready = rdy;
        step();
        tick = 1'b0;
    endtask

    task automatic runSweep(input logic [7:0] spk, input bit rdy, output int cycles);
        applyStimulus(1'b1, spk, rdy);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!obsDone && cycles < 300);
        if (!obsDone) checkOutput("sweep_end_within_bound", 0, 1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_out_valid", int'(outIf.out_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_sweep_done", int'(sweepDone), 0);
        checkOutput("rst_tick_overrun", int'(tickOverrun), 0);
        checkOutput("rst_out_id", int'(outIf.out_id), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic writeThresh(input logic [7:0] th);
        cfgThresh = th;
        cfgWe = 1'b1;
        step();
        cfgWe = 1'b0;
    endtask

    int c;
    int lastId;
    int lit2[7] = '{64, 120, 169, 0, 0, 0, 64};
    int lit4[6] = '{64, 120, 169, 212, 250, 0};

    initial begin
        outIf.out_ready = 1'b1;
        modelReset();
        #1;

        // Reset, then a quiet sweep of exactly eight update cycles.
        doReset();
        runSweep(8'h00, 1'b1, c);
        checkOutput("t1_sweep_len", c, 9);

        // Neuron 0 integrates, fires on the 4th sweep, sits out two, restarts.
        doReset();
        for (int k = 0; k < 7; k++) begin
            runSweep(8'h01, 1'b1, c);
            checkOutput($sformatf("t2_v0_model_s%0d", k + 1), mv[0], lit2[k]);
            checkOutput($sformatf("t2_v0_dut_s%0d", k + 1), int'(dut.v_q[0]), lit2[k]);
            checkOutput($sformatf("t2_len_s%0d", k + 1), c, (k == 3) ? 10 : 9);
        end

        // Leak only.
        doReset();
        runSweep(8'h08, 1'b1, c);
        runSweep(8'h08, 1'b1, c);
        checkOutput("t3_v3_charged", int'(dut.v_q[3]), 120);
        runSweep(8'h00, 1'b1, c);
        checkOutput("t3_v3_leak1", int'(dut.v_q[3]), 105);
        runSweep(8'h00, 1'b1, c);
        checkOutput("t3_v3_leak2", int'(dut.v_q[3]), 92);

        // Saturation at threshold 255.
        doReset();
        writeThresh(8'd255);
        for (int k = 0; k < 6; k++) begin
            runSweep(8'h04, 1'b1, c);
            checkOutput($sformatf("t4_v2_model_s%0d", k + 1), mv[2], lit4[k]);
            checkOutput($sformatf("t4_v2_dut_s%0d", k + 1), int'(dut.v_q[2]), lit4[k]);
        end
        checkOutput("t4_fire_len", c, 10);

        // Backpressure on a two-event sweep.
        doReset();
        for (int k = 0; k < 3; k++) runSweep(8'h81, 1'b1, c);
        applyStimulus(1'b1, 8'h81, 1'b0);
        c = 0;
        do begin
            step();
            c++;
        end while (!obsValid && c < 20);
        checkOutput("t5_first_event_cycle", c, 2);
        for (int k = 0; k < 4; k++) begin
            step();
            c++;
            checkOutput("t5_stall_valid", int'(obsValid), 1);
            checkOutput("t5_stall_id", obsId, 0);
            checkOutput("t5_stall_v1", int'(dut.v_q[1]), 0);
        end
        outIf.out_ready = 1'b1;
        lastId = -1;
        do begin
            step();
            c++;
            if (obsValid) lastId = obsId;
        end while (!obsDone && c < 300);
        checkOutput("t5_second_id", lastId, 7);
        checkOutput("t5_sweep_len", c, 16);

        // Overrun tick mid-sweep, then reset during an event.
        doReset();
        applyStimulus(1'b1, 8'h00, 1'b1);
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        c = 3;
        do begin
            step();
            c++;
        end while (!obsDone && c < 300);
        checkOutput("t6_len_with_overrun", c, 9);
        checkOutput("t6_overrun_set", int'(tickOverrun), 1);
        runSweep(8'hFE, 1'b1, c);
        writeThresh(8'd50);
        applyStimulus(1'b1, 8'h01, 1'b0);
        c = 0;
        do begin
            step();
            c++;
        end while (!obsValid && c < 20);
        checkOutput("t6_emit_reached", int'(obsValid), 1);
        checkOutput("t6_v5_before_reset", int'(dut.v_q[5]), 64);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("t6_rst_valid", int'(outIf.out_valid), 0);
        checkOutput("t6_rst_busy", int'(busy), 0);
        checkOutput("t6_rst_overrun", int'(tickOverrun), 0);
        for (int i = 0; i < N; i++) checkOutput($sformatf("t6_rst_v%0d", i), int'(dut.v_q[i]), 0);
        step();
        rst_n = 1'b1;
        outIf.out_ready = 1'b1;
        step();

        // Random traffic with backpressure, threshold writes and one mid-run reset.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            tick = ($urandom_range(0, 7) == 0);
            spikeIn = 8'($urandom);
            outIf.out_ready = ($urandom_range(0, 3) != 0);
            cfgWe = ($urandom_range(0, 63) == 0);
            cfgThresh = 8'($urandom_range(40, 255));
            if (n == 1500) begin
                rst_n = 1'b0;
                modelReset();
            end else begin
                rst_n = 1'b1;
            end
            step();
        end
        tick = 1'b0;
        cfgWe = 1'b0;
        rst_n = 1'b1;
        outIf.out_ready = 1'b1;
        for (int n = 0; n < 40; n++) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
